ga_register_writer: RTL

GA_REGISTER_WRITER -- requirements
Module: ga_register_writer

---
 rtl/ga_register_writer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ga_register_writer.sv
// ga_register_writer
// Gate-array register write port: decodes Z80 OUT writes to the gate array
// (A15=1, A14=0) into pen select, palette colour, mode/ROM config and,
// optionally, RAM bank configuration.
//
// Build option:
//   GA_RAMCFG_EN  - when defined, adds the RAMCFG output and decodes
//                   D[7:6]=11 as a RAM configuration write. When undefined,
//                   RAMCFG is absent and D[7:6]=11 writes are ignored.
//
// Timing: one accept per bus write (rising edge of the decoded access).
// Every register and strobe output updates on the clock edge that samples
// the accept. MODE is deferred to the next HSYNC rising edge.

module ga_register_writer (
    input  logic       CLK,
    input  logic       RESET_n,
    input  logic       IORQ_n,
    input  logic       WR_n,
    input  logic       M1_n,
    input  logic       A15,
    input  logic       A14,
    input  logic [7:0] D,
    input  logic       HSYNC,
    output logic       LROMEN,
    output logic       HROMEN,
    output logic [1:0] MODE,
    output logic [4:0] INK_SEL,
    output logic [4:0] INK_COLOUR,
    output logic       INK_WE,
    output logic       IRQ_CLR
`ifdef GA_RAMCFG_EN
    ,
    output logic [5:0] RAMCFG
`endif
);

    localparam int unsigned MODE_W   = 2;
    localparam int unsigned PEN_W    = 5;
    localparam int unsigned COLOUR_W = 5;
    localparam int unsigned BORDER   = 16;

    // Command field carried in D[7:6].
    typedef enum logic [1:0] {
        CMD_PEN = 2'b00,
        CMD_INK = 2'b01,
        CMD_CFG = 2'b10,
        CMD_RAM = 2'b11
    } cmd_e;

    logic              access_c;
    logic              accept_c;
    logic              hs_rise_c;
    cmd_e              cmd_c;
    logic              access_q;
    logic              hsync_q;
    logic [MODE_W-1:0] mode_pending_q;
    logic              pend_q;
    logic              unused_d5_c;

    // D[5] only matters for RAM configuration writes.
    assign unused_d5_c = D[5];

    // Bus decode: access qualification, single-accept edge detect, HSYNC edge.
    always_comb begin
        access_c  = 1'b0;
        accept_c  = 1'b0;
        hs_rise_c = 1'b0;
        cmd_c     = CMD_PEN;
        access_c  = ~IORQ_n & ~WR_n & M1_n & A15 & ~A14;
        accept_c  = access_c & ~access_q;
        hs_rise_c = HSYNC & ~hsync_q;
        cmd_c     = cmd_e'(D[7:6]);
    end

    // Register file, strobes and deferred mode update.
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            // A strobe held across reset release must not be accepted.
            access_q       <= access_c;
            hsync_q        <= 1'b0;
            LROMEN         <= 1'b0;
            HROMEN         <= 1'b0;
            MODE           <= '0;
            mode_pending_q <= '0;
            pend_q         <= 1'b0;
            INK_SEL        <= '0;
            INK_COLOUR     <= '0;
            INK_WE         <= 1'b0;
            IRQ_CLR        <= 1'b0;
`ifdef GA_RAMCFG_EN
            RAMCFG         <= '0;
`endif
        end else begin
            access_q <= access_c;
            hsync_q  <= HSYNC;
            INK_WE   <= 1'b0;
            IRQ_CLR  <= 1'b0;

            // Pending mode lands on HSYNC rise; a same-cycle config write
            // below re-arms pend with the new value for the next rise.
            if (hs_rise_c && pend_q) begin
                MODE   <= mode_pending_q;
                pend_q <= 1'b0;
            end

            if (accept_c) begin
                case (cmd_c)
                    CMD_PEN: begin
                        INK_SEL <= D[4] ? PEN_W'(BORDER) : {1'b0, D[3:0]};
                    end
                    CMD_INK: begin
                        INK_COLOUR <= COLOUR_W'(D[4:0]);
                        INK_WE     <= 1'b1;
                    end
                    CMD_CFG: begin
                        LROMEN         <= D[2];
                        HROMEN         <= D[3];
                        mode_pending_q <= MODE_W'(D[1:0]);
                        pend_q         <= 1'b1;
                        IRQ_CLR        <= D[4];
                    end
                    CMD_RAM: begin
`ifdef GA_RAMCFG_EN
                        RAMCFG <= D[5:0];
`endif
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
